// File: rtl/axis_burst_aligner_pkg.sv
// axis_burst_aligner_pkg: shared state encoding, pad default and clogb2 helper for the burst aligner
package axis_burst_aligner_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, STREAM = 2'd1, PAD = 2'd2} state_t;
  localparam int C_PAD_VALUE_DEFAULT = 0;
  function automatic int clogb2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction
endpackage

// File: rtl/axis_sync_fifo.sv
// axis_sync_fifo: first-word-fall-through FIFO with occupancy count and synchronous clear
module axis_sync_fifo
  import axis_burst_aligner_pkg::*;
#(
  parameter int C_WIDTH = 37,
  parameter int C_DEPTH = 512
) (
  input  logic                      ACLK,
  input  logic                      ARESET,
  input  logic                      clr,
  input  logic                      push,
  input  logic [C_WIDTH-1:0]        din,
  input  logic                      pop,
  output logic [C_WIDTH-1:0]        dout,
  output logic [clogb2(C_DEPTH):0]  count,
  output logic                      full
);
  localparam int AW = clogb2(C_DEPTH);
  logic [C_WIDTH-1:0] mem [C_DEPTH];
  logic [AW-1:0] wptr, rptr;
  always_ff @(posedge ACLK)
    if (push) mem[wptr] <= din;
  always_ff @(posedge ACLK)
    if (ARESET || clr) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      wptr  <= wptr + AW'(push);
      rptr  <= rptr + AW'(pop);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  assign dout = mem[rptr];
  assign full = count == (AW+1)'(C_DEPTH);
endmodule

// File: rtl/axis_burst_aligner.sv
// axis_burst_aligner: re-emits an AXI4-Stream as fixed C_BURST_LEN bursts, padding short packets.
// Optional statistics counters are enabled by defining AXIS_BURST_ALIGNER_STATS_EN.
module axis_burst_aligner
  import axis_burst_aligner_pkg::*;
#(
  parameter int C_AXI_DATA_WIDTH = 32,
  parameter int C_BURST_LEN      = 256,
  parameter int C_FIFO_DEPTH     = 512,
  parameter logic [C_AXI_DATA_WIDTH-1:0] C_PAD_VALUE = C_AXI_DATA_WIDTH'(C_PAD_VALUE_DEFAULT)
) (
  input  logic                            ACLK,
  input  logic                            ARESET,
  input  logic                            sw_reset,
  output logic                            sw_reset_ok,
  input  logic                            S_AXIS_TVALID,
  output logic                            S_AXIS_TREADY,
  input  logic [C_AXI_DATA_WIDTH-1:0]     S_AXIS_TDATA,
  input  logic [C_AXI_DATA_WIDTH/8-1:0]   S_AXIS_TSTRB,
  input  logic                            S_AXIS_TLAST,
  output logic                            M_AXIS_TVALID,
  input  logic                            M_AXIS_TREADY,
  output logic [C_AXI_DATA_WIDTH-1:0]     M_AXIS_TDATA,
  output logic [C_AXI_DATA_WIDTH/8-1:0]   M_AXIS_TSTRB,
  output logic                            M_AXIS_TLAST,
  output logic                            burst_ready,
  output logic [clogb2(C_FIFO_DEPTH):0]   fill_level
`ifdef AXIS_BURST_ALIGNER_STATS_EN
  ,
  output logic [31:0]                     stat_words_in,
  output logic [31:0]                     stat_bursts_out,
  output logic [31:0]                     stat_pad_beats
`endif
);
  localparam int DW = C_AXI_DATA_WIDTH;
  localparam int SW = DW / 8;
  localparam int EW = 1 + SW + DW;
  localparam int FW = clogb2(C_FIFO_DEPTH) + 1;
  localparam int CW = clogb2(C_BURST_LEN);
  localparam logic [CW-1:0] LAST_BEAT = CW'(C_BURST_LEN - 1);
  state_t state, state_nxt;
  logic [CW-1:0] beat, beat_nxt;
  logic [FW-1:0] pending_flush;
  logic [EW-1:0] head;
  logic full, push, pop, hs, head_last, at_end, start;
  axis_sync_fifo #(.C_WIDTH(EW), .C_DEPTH(C_FIFO_DEPTH)) u_fifo (
    .ACLK   (ACLK),
    .ARESET (ARESET),
    .clr    (sw_reset),
    .push   (push),
    .din    ({S_AXIS_TLAST, S_AXIS_TSTRB, S_AXIS_TDATA}),
    .pop    (pop),
    .dout   (head),
    .count  (fill_level),
    .full   (full)
  );
  assign S_AXIS_TREADY = !full && !sw_reset;
  assign push          = S_AXIS_TVALID && S_AXIS_TREADY;
  assign M_AXIS_TVALID = state != IDLE && !sw_reset;
  assign hs            = M_AXIS_TVALID && M_AXIS_TREADY;
  assign pop           = hs && state == STREAM;
  assign head_last     = head[EW-1];
  assign at_end        = beat == LAST_BEAT;
  assign start         = state == IDLE && burst_ready && !sw_reset;
  assign M_AXIS_TDATA  = state == STREAM ? head[DW-1:0] : C_PAD_VALUE;
  assign M_AXIS_TSTRB  = state == STREAM ? head[DW+SW-1:DW] : '0;
  assign M_AXIS_TLAST  = M_AXIS_TVALID && at_end;
  always_comb begin
    state_nxt = state;
    beat_nxt  = beat;
    if (start) begin
      state_nxt = STREAM;
      beat_nxt  = '0;
    end else if (hs) begin
      beat_nxt  = beat + CW'(1);
      state_nxt = at_end ? IDLE : (state == STREAM && head_last) ? PAD : state;
    end
  end
  // burst_ready is suppressed on the start cycle so it never lingers into STREAM
  always_ff @(posedge ACLK)
    if (ARESET || sw_reset) begin
      state         <= IDLE;
      beat          <= '0;
      pending_flush <= '0;
      burst_ready   <= 1'b0;
    end else begin
      state         <= state_nxt;
      beat          <= beat_nxt;
      pending_flush <= pending_flush + FW'(push && S_AXIS_TLAST) - FW'(pop && head_last);
      burst_ready   <= state == IDLE && !start && (fill_level >= FW'(C_BURST_LEN) || pending_flush != '0);
    end
  always_ff @(posedge ACLK)
    if (ARESET) sw_reset_ok <= 1'b0;
    else sw_reset_ok <= sw_reset;
`ifdef AXIS_BURST_ALIGNER_STATS_EN
  always_ff @(posedge ACLK)
    if (ARESET || sw_reset) begin
      stat_words_in   <= '0;
      stat_bursts_out <= '0;
      stat_pad_beats  <= '0;
    end else begin
      stat_words_in   <= stat_words_in + 32'(push);
      stat_bursts_out <= stat_bursts_out + 32'(hs && at_end);
      stat_pad_beats  <= stat_pad_beats + 32'(hs && state == PAD);
    end
`endif
endmodule

// File: tb/tb_axis_burst_aligner.sv
// tb_axis_burst_aligner: vector table, corner sequences and random traffic against a packet-level burst model
module tb_axis_burst_aligner;
  import axis_burst_aligner_pkg::*;
  localparam int DW = 32, SW = DW / 8, BL = 256, DEPTH = 512, FW = clogb2(DEPTH) + 1;
  localparam logic [DW-1:0] PADV = '0;
  logic ACLK = 0, ARESET = 1, sw_reset = 0, sw_reset_ok;
  logic S_AXIS_TVALID = 0, S_AXIS_TREADY, S_AXIS_TLAST = 0;
  logic [DW-1:0] S_AXIS_TDATA = '0;
  logic [SW-1:0] S_AXIS_TSTRB = '0;
  logic M_AXIS_TVALID, M_AXIS_TREADY = 0, M_AXIS_TLAST;
  logic [DW-1:0] M_AXIS_TDATA;
  logic [SW-1:0] M_AXIS_TSTRB;
  logic burst_ready;
  logic [FW-1:0] fill_level;
`ifdef AXIS_BURST_ALIGNER_STATS_EN
  logic [31:0] stat_words_in, stat_bursts_out, stat_pad_beats;
`endif
  axis_burst_aligner #(.C_AXI_DATA_WIDTH(DW), .C_BURST_LEN(BL), .C_FIFO_DEPTH(DEPTH), .C_PAD_VALUE(PADV)) dut (
    .ACLK(ACLK), .ARESET(ARESET), .sw_reset(sw_reset), .sw_reset_ok(sw_reset_ok),
    .S_AXIS_TVALID(S_AXIS_TVALID), .S_AXIS_TREADY(S_AXIS_TREADY), .S_AXIS_TDATA(S_AXIS_TDATA),
    .S_AXIS_TSTRB(S_AXIS_TSTRB), .S_AXIS_TLAST(S_AXIS_TLAST),
    .M_AXIS_TVALID(M_AXIS_TVALID), .M_AXIS_TREADY(M_AXIS_TREADY), .M_AXIS_TDATA(M_AXIS_TDATA),
    .M_AXIS_TSTRB(M_AXIS_TSTRB), .M_AXIS_TLAST(M_AXIS_TLAST),
    .burst_ready(burst_ready), .fill_level(fill_level)
`ifdef AXIS_BURST_ALIGNER_STATS_EN
    , .stat_words_in(stat_words_in), .stat_bursts_out(stat_bursts_out), .stat_pad_beats(stat_pad_beats)
`endif
  );
  always #5 ACLK = ~ACLK;
  typedef struct { logic [DW-1:0] data; logic [SW-1:0] strb; logic last; logic pad; } beat_t;
  typedef struct { int n; bit last; int bursts; int pads; int base; } vec_t;
  beat_t exp_q[$];
  vec_t vecs[7];
  int checks = 0, failures = 0;
  int pos = 0, held = 0, beats = 0, bursts = 0, pads = 0;
  bit done;
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask
  // Model: each accepted word takes the next burst slot; a TLAST word pads the rest of its burst.
  always @(negedge ACLK) begin
    if (ARESET) begin
      exp_q.delete(); pos = 0; held = 0;
    end else begin
      check("fill_level", fill_level, held);
      check("s_tready", S_AXIS_TREADY, held != DEPTH && !sw_reset);
      if (dut.state == STREAM) check("stream_nonempty", fill_level != 0, 1);
      if (sw_reset) begin
        exp_q.delete(); pos = 0; held = 0;
      end else begin
        if (M_AXIS_TVALID && M_AXIS_TREADY) begin
          beats++;
          if (M_AXIS_TLAST) bursts++;
          if (M_AXIS_TSTRB == 0) pads++;
          if (exp_q.size() == 0) check("beat_expected", exp_q.size() != 0, 1);
          else begin
            beat_t e;
            e = exp_q.pop_front();
            check("m_tdata", M_AXIS_TDATA, e.data);
            check("m_tstrb", M_AXIS_TSTRB, e.strb);
            check("m_tlast", M_AXIS_TLAST, e.last);
            if (!e.pad) held--;
          end
        end
        if (S_AXIS_TVALID && S_AXIS_TREADY) begin
          exp_q.push_back('{S_AXIS_TDATA, S_AXIS_TSTRB, pos == BL - 1, 1'b0});
          pos++;
          held++;
          if (S_AXIS_TLAST)
            while (pos < BL) begin
              exp_q.push_back('{PADV, '0, pos == BL - 1, 1'b1});
              pos++;
            end
          if (pos == BL) pos = 0;
        end
      end
    end
  end
  task automatic send(input int n, input bit last, input int base, input bit rnd);
    for (int i = 0; i < n; i++) begin
      int t;
      if (rnd) while ($urandom_range(0, 3) == 0) begin @(posedge ACLK); #1; end
      S_AXIS_TVALID = 1;
      S_AXIS_TDATA  = DW'(base + i);
      S_AXIS_TSTRB  = rnd ? SW'($urandom_range(1, 15)) : '1;
      S_AXIS_TLAST  = last && (i == n - 1);
      t = 0;
      @(negedge ACLK);
      while (!S_AXIS_TREADY && t < 20000) begin @(negedge ACLK); t++; end
      if (t >= 20000) check("send_timeout", t, 0);
      @(posedge ACLK); #1;
      S_AXIS_TVALID = 0;
      S_AXIS_TLAST  = 0;
    end
  endtask
  task automatic wait_idle();
    int t;
    t = 0;
    do begin @(posedge ACLK); #1; t++; end
    while (!(fill_level == 0 && !M_AXIS_TVALID) && t < 20000);
    check("idle_timeout", t < 20000, 1);
    repeat (4) begin @(posedge ACLK); #1; end
  endtask
  task automatic run_vec(input int n, input bit last, input int eb, input int ep, input int base);
    int b0, p0;
    b0 = bursts;
    p0 = pads;
    send(n, last, base, 0);
    wait_idle();
    check("bursts", bursts - b0, eb);
    check("pad_beats", pads - p0, ep);
    check("fill_after", fill_level, 0);
    check("burst_ready_after", burst_ready, 0);
    check("pending_after", dut.pending_flush, 0);
    check("model_drained", exp_q.size(), 0);
  endtask
  task automatic pulse_sw_reset();
    sw_reset = 1;
    @(posedge ACLK); #1;
    check("swr_ok_high", sw_reset_ok, 1);
    check("swr_m_tvalid", M_AXIS_TVALID, 0);
    check("swr_fill", fill_level, 0);
    check("swr_s_tready", S_AXIS_TREADY, 0);
    sw_reset = 0;
    @(posedge ACLK); #1;
    check("swr_ok_low", sw_reset_ok, 0);
    check("swr_idle", M_AXIS_TVALID, 0);
  endtask
  initial begin
    #900000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int t, b0;
    vecs[0] = '{256, 1'b0, 1, 0, 0};
    vecs[1] = '{10, 1'b1, 1, 246, 1};
    vecs[2] = '{256, 1'b1, 1, 0, 'h1000};
    vecs[3] = '{1, 1'b1, 1, 255, 'h2000};
    vecs[4] = '{255, 1'b1, 1, 1, 'h3000};
    vecs[5] = '{257, 1'b1, 2, 255, 'h4000};
    vecs[6] = '{512, 1'b0, 2, 0, 'h5000};
    repeat (3) @(posedge ACLK);
    #1 ARESET = 0;
    check("rst_m_tvalid", M_AXIS_TVALID, 0);
    check("rst_m_tlast", M_AXIS_TLAST, 0);
    check("rst_m_tdata", M_AXIS_TDATA, 0);
    check("rst_m_tstrb", M_AXIS_TSTRB, 0);
    check("rst_burst_ready", burst_ready, 0);
    check("rst_fill", fill_level, 0);
    check("rst_sw_reset_ok", sw_reset_ok, 0);
    M_AXIS_TREADY = 1;
    for (int v = 0; v < 7; v++) run_vec(vecs[v].n, vecs[v].last, vecs[v].bursts, vecs[v].pads, vecs[v].base);
    // backpressure until full, then two bursts under alternating ready
    M_AXIS_TREADY = 0;
    b0 = bursts;
    fork
      send(600, 0, 'h10000, 0);
      begin
        t = 0;
        while (fill_level != FW'(DEPTH) && t < 2000) begin @(posedge ACLK); #1; t++; end
        repeat (10) begin @(posedge ACLK); #1; end
        check("full_fill", fill_level, DEPTH);
        check("full_s_tready", S_AXIS_TREADY, 0);
        t = 0;
        while (bursts - b0 < 2 && t < 5000) begin @(posedge ACLK); #1; M_AXIS_TREADY = ~M_AXIS_TREADY; t++; end
        M_AXIS_TREADY = 0;
      end
    join
    repeat (4) begin @(posedge ACLK); #1; end
    check("bp_bursts", bursts - b0, 2);
    check("bp_leftover", fill_level, 88);
    check("bp_model_left", exp_q.size(), 88);
    pulse_sw_reset();
    M_AXIS_TREADY = 0;
    send(256, 0, 'h20000, 0);
    M_AXIS_TREADY = 1;
    b0 = beats;
    t = 0;
    while (beats - b0 < 100 && t < 1000) begin @(posedge ACLK); #1; t++; end
    check("beats_before_flush", beats - b0, 100);
    pulse_sw_reset();
    run_vec(256, 0, 1, 0, 'h30000);
`ifdef AXIS_BURST_ALIGNER_STATS_EN
    pulse_sw_reset();
    run_vec(10, 1, 1, 246, 1);
    run_vec(256, 0, 1, 0, 0);
    check("stat_words_in", stat_words_in, 266);
    check("stat_bursts_out", stat_bursts_out, 2);
    check("stat_pad_beats", stat_pad_beats, 246);
`endif
    done = 0;
    fork
      begin
        for (int k = 0; k < 12; k++)
          send($urandom_range(1, 300), k == 11 || $urandom_range(0, 1) == 1, 'h100000 + k * 'h1000, 1);
        done = 1;
      end
      begin
        while (!done) begin @(posedge ACLK); #1; M_AXIS_TREADY = $urandom_range(0, 3) != 0; end
        M_AXIS_TREADY = 1;
      end
    join
    wait_idle();
    check("rand_model_drained", exp_q.size(), 0);
    check("rand_pending", dut.pending_flush, 0);
    check("rand_fill", fill_level, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
